// File: rtl/regfile_bcd_display.sv
// regfile_bcd_display: register file with a live decimal readout on active-low 7-segment digits
module regfile_bcd_display #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DIGITS   = 3,
    parameter int LZ_BLANK = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   data,
    input  logic                en,
    input  logic                rw,
    output logic [7*DIGITS-1:0] LED,
    output logic                busy,
    output logic                ovf
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NDIG  = (DATA_W + 2) / 3;
    localparam int BW    = 4 * NDIG;
    localparam int MAXD  = NDIG > DIGITS ? NDIG : DIGITS;
    localparam int CW    = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    state_t              state_q;
    logic [DATA_W-1:0]   src_q, last_q, dv;
    logic [BW-1:0]       bcd_q, bcd_adj;
    logic [CW-1:0]       cnt_q;
    logic                pending_q;
    logic [4*MAXD-1:0]   bcd_ext;
    logic [7*DIGITS-1:0] led_d;
    logic                ovf_d, nz;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    assign dv      = rw ? data : mem_q[adr];
    assign bcd_ext = (4*MAXD)'(bcd_q);

    // Register array: reset to identity contents, written whenever rw and en are both high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i);
        else if (rw && en)
            mem_q[adr] <= data;
    end

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the next shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NDIG; k++)
            if (bcd_q[4*k+:4] >= 4'd5) bcd_adj[4*k+:4] = bcd_q[4*k+:4] + 4'd3;
    end

    // Segment encoding from the finished BCD word; nz tracks a nonzero digit at or above k
    always_comb begin
        ovf_d = |(bcd_ext >> (4*DIGITS));
        nz    = ovf_d;
        led_d = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz = nz | (bcd_ext[4*k+:4] != 4'd0);
            led_d[7*k+:7] = ovf_d ? SEG_DASH :
                            (LZ_BLANK != 0 && k > 0 && !nz) ? SEG_BLANK : seg(bcd_ext[4*k+:4]);
        end
    end

    // Conversion FSM: latch a changed value, shift DATA_W times, then load the display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            last_q    <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b1;
            LED       <= {DIGITS{SEG_ZERO}};
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pending_q || dv != last_q) begin
                    src_q     <= dv;
                    last_q    <= dv;
                    bcd_q     <= '0;
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                    busy      <= 1'b1;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, src_q} <= {bcd_adj, src_q} << 1;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) state_q <= LOAD;
                end
                LOAD: begin
                    LED     <= led_d;
                    ovf     <= ovf_d;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_bcd_display.sv
// tb_regfile_bcd_display: directed checks on default, 2-digit and leading-zero-blanking instances
module tb_regfile_bcd_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111, DS = 7'b0111111;

    logic        clk = 0, rst = 1, en = 0, rw = 0;
    logic [3:0]  adr = 0;
    logic [7:0]  data = 0;
    logic [20:0] led_a, led_c;
    logic [13:0] led_b;
    logic        busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    int          checks = 0, errors = 0;

    regfile_bcd_display u_dut (.clk(clk), .rst(rst), .adr(adr), .data(data), .en(en), .rw(rw),
                               .LED(led_a), .busy(busy_a), .ovf(ovf_a));
    regfile_bcd_display #(.DIGITS(2)) u_d2 (.clk(clk), .rst(rst), .adr(adr), .data(data), .en(en), .rw(rw),
                               .LED(led_b), .busy(busy_b), .ovf(ovf_b));
    regfile_bcd_display #(.LZ_BLANK(1)) u_lz (.clk(clk), .rst(rst), .adr(adr), .data(data), .en(en), .rw(rw),
                               .LED(led_c), .busy(busy_c), .ovf(ovf_c));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_settle(output int convs, output int bcyc);
        int low = 0;
        logic prev = 0;
        convs = 0;
        bcyc = 0;
        for (int c = 0; c < 200 && low < 2; c++) begin
            step();
            if (busy_a && !prev) convs++;
            if (busy_a) bcyc++;
            low = busy_a ? 0 : low + 1;
            prev = busy_a;
        end
        checks++;
        if (low < 2) begin errors++; $display("FAIL settle_timeout: busy=%b required 0", busy_a); end
    endtask

    task automatic test_reset();
        int convs, bcyc;
        repeat (2) step();
        checks++; if (led_a !== {S0, S0, S0}) begin errors++; $display("FAIL reset_led: %h required %h", led_a, {S0, S0, S0}); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: %b required 0", ovf_a); end
        checks++; if (led_b !== {S0, S0}) begin errors++; $display("FAIL reset_led_d2: %h required %h", led_b, {S0, S0}); end
        rst = 0;
        wait_settle(convs, bcyc);
        checks++; if (convs !== 1) begin errors++; $display("FAIL reset_pending_convs: %0d required 1", convs); end
        checks++; if (bcyc !== 9) begin errors++; $display("FAIL reset_busy_cycles: %0d required 9", bcyc); end
        checks++; if (led_a !== {S0, S0, S0}) begin errors++; $display("FAIL reset_led_after: %h required %h", led_a, {S0, S0, S0}); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_after: %b required 0", ovf_a); end
    endtask

    task automatic test_read();
        int convs, bcyc, n;
        adr = 15;
        wait_settle(convs, bcyc);
        checks++; if (bcyc !== 9) begin errors++; $display("FAIL read15_busy_cycles: %0d required 9", bcyc); end
        checks++; if (led_a !== {S0, S1, S5}) begin errors++; $display("FAIL read15_led: %h required %h", led_a, {S0, S1, S5}); end
        checks++; if (led_b !== {S1, S5}) begin errors++; $display("FAIL read15_led_d2: %h required %h", led_b, {S1, S5}); end
        checks++; if (led_c !== {BL, S1, S5}) begin errors++; $display("FAIL read15_led_lz: %h required %h", led_c, {BL, S1, S5}); end
        adr = 7;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            n++;
            if (led_a === {S0, S0, S7}) break;
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL read7_latency: %0d edges required 10", n); end
        checks++; if (led_c !== {BL, BL, S7}) begin errors++; $display("FAIL read7_led_lz: %h required %h", led_c, {BL, BL, S7}); end
        wait_settle(convs, bcyc);
    endtask

    task automatic test_write();
        int convs, bcyc;
        rw = 1; en = 1; adr = 3; data = 255;
        step();
        rw = 0; en = 0;
        wait_settle(convs, bcyc);
        checks++; if (led_a !== {S2, S5, S5}) begin errors++; $display("FAIL write255_led: %h required %h", led_a, {S2, S5, S5}); end
        checks++; if (ovf_b !== 1'b1 || led_b !== {DS, DS}) begin errors++; $display("FAIL write255_d2: ovf=%b led=%h required 1 %h", ovf_b, led_b, {DS, DS}); end
        rw = 1; en = 0; adr = 4; data = 100;
        step();
        rw = 0;
        wait_settle(convs, bcyc);
        checks++; if (convs !== 2) begin errors++; $display("FAIL nowrite_convs: %0d required 2", convs); end
        checks++; if (led_a !== {S0, S0, S4}) begin errors++; $display("FAIL nowrite_led: %h required %h", led_a, {S0, S0, S4}); end
    endtask

    task automatic test_back_to_back();
        int rises = 0, low = 0;
        logic prev = 0, saw9 = 0;
        adr = 5;
        for (int c = 1; c < 100 && low < 2; c++) begin
            step();
            if (c == 2) adr = 9;
            if (c == 4) adr = 12;
            if (busy_a && !prev) rises++;
            if (led_a === {S0, S0, S9}) saw9 = 1;
            low = busy_a ? 0 : low + 1;
            prev = busy_a;
        end
        checks++; if (rises !== 2) begin errors++; $display("FAIL b2b_convs: %0d required 2", rises); end
        checks++; if (saw9 !== 1'b0) begin errors++; $display("FAIL b2b_saw_009: %b required 0", saw9); end
        checks++; if (led_a !== {S0, S1, S2}) begin errors++; $display("FAIL b2b_led: %h required %h", led_a, {S0, S1, S2}); end
    endtask

    task automatic test_overflow();
        int convs, bcyc;
        rw = 1; en = 0; data = 200;
        wait_settle(convs, bcyc);
        checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf200_flag: %b required 1", ovf_b); end
        checks++; if (led_b !== {DS, DS}) begin errors++; $display("FAIL ovf200_led_d2: %h required %h", led_b, {DS, DS}); end
        checks++; if (ovf_a !== 1'b0 || led_a !== {S2, S0, S0}) begin errors++; $display("FAIL ovf200_default: ovf=%b led=%h required 0 %h", ovf_a, led_a, {S2, S0, S0}); end
        data = 99;
        wait_settle(convs, bcyc);
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf99_flag: %b required 0", ovf_b); end
        checks++; if (led_b !== {S9, S9}) begin errors++; $display("FAIL ovf99_led_d2: %h required %h", led_b, {S9, S9}); end
        checks++; if (led_c !== {BL, S9, S9}) begin errors++; $display("FAIL ovf99_led_lz: %h required %h", led_c, {BL, S9, S9}); end
    endtask

    task automatic test_lz();
        int convs, bcyc;
        data = 7;
        wait_settle(convs, bcyc);
        checks++; if (led_c !== {BL, BL, S7}) begin errors++; $display("FAIL lz7_led: %h required %h", led_c, {BL, BL, S7}); end
        checks++; if (led_a !== {S0, S0, S7}) begin errors++; $display("FAIL lz7_default: %h required %h", led_a, {S0, S0, S7}); end
        data = 0;
        wait_settle(convs, bcyc);
        checks++; if (led_c !== {BL, BL, S0}) begin errors++; $display("FAIL lz0_led: %h required %h", led_c, {BL, BL, S0}); end
        data = 100;
        wait_settle(convs, bcyc);
        checks++; if (led_c !== {S1, S0, S0}) begin errors++; $display("FAIL lz100_led: %h required %h", led_c, {S1, S0, S0}); end
    endtask

    task automatic test_reset_mid();
        int convs, bcyc;
        data = 123;
        step();
        repeat (3) step();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_busy_before: %b required 1", busy_a); end
        rst = 1;
        #1;
        checks++; if (led_a !== {S0, S0, S0} || busy_a !== 1'b0) begin errors++; $display("FAIL mid_reset_led: led=%h busy=%b required %h 0", led_a, busy_a, {S0, S0, S0}); end
        checks++; if (led_c !== {S0, S0, S0}) begin errors++; $display("FAIL mid_reset_led_lz: %h required %h", led_c, {S0, S0, S0}); end
        rw = 0; adr = 3;
        step();
        rst = 0;
        wait_settle(convs, bcyc);
        checks++; if (led_a !== {S0, S0, S3}) begin errors++; $display("FAIL mem3_after_reset: %h required %h", led_a, {S0, S0, S3}); end
        checks++; if (led_c !== {BL, BL, S3}) begin errors++; $display("FAIL mem3_after_reset_lz: %h required %h", led_c, {BL, BL, S3}); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_overflow();
        test_lz();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
